// File: rtl/lsu_stage.sv
// Load/store pipeline stage: decodes LOAD/STORE against a single data-memory
// port, passes every other opcode through, and reports alignment, illegal-size
// and access-timeout exceptions with a fixed IDLE/REQ/DONE handshake.
module lsu_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned EX_W       = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pipeline_in_valid,
  input  logic [4:0]            opcode_in,
  input  logic [2:0]            funct_in,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [XLEN-1:0]       result_in,
  input  logic [REG_ADDR_W-1:0] rd_addr_in,
  input  logic [EX_W-1:0]       exception_in,
  input  logic                  exception_in_valid,
  output logic                  pipeline_out_valid,
  output logic [XLEN-1:0]       result_out,
  output logic [REG_ADDR_W-1:0] rd_addr_out,
  output logic [EX_W-1:0]       exception_out,
  output logic                  exception_out_valid,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [XLEN-1:0]       mem_wr_data,
  output logic [XLEN/8-1:0]     mem_byte_en,
  input  logic                  mem_ready,
  input  logic [XLEN-1:0]       mem_rd_data,
  input  logic                  flush,
  input  logic                  stall_in,
  output logic                  stall_out
);

  localparam int unsigned NB    = XLEN / 8;
  localparam int unsigned OFFW  = $clog2(NB);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;

  localparam logic [EX_W-1:0] EX_ILLEGAL   = EX_W'(2);
  localparam logic [EX_W-1:0] EX_LD_MISAL  = EX_W'(4);
  localparam logic [EX_W-1:0] EX_LD_FAULT  = EX_W'(5);
  localparam logic [EX_W-1:0] EX_ST_MISAL  = EX_W'(6);
  localparam logic [EX_W-1:0] EX_ST_FAULT  = EX_W'(7);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2:0]            funct_q, funct_d;
  logic [OFFW-1:0]       off_q, off_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     maddr_q, maddr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic [NB-1:0]         be_q, be_d;
  logic                  vld_q, vld_d;
  logic [XLEN-1:0]       res_q, res_d;
  logic [REG_ADDR_W-1:0] rdo_q, rdo_d;
  logic [EX_W-1:0]       exc_q, exc_d;
  logic                  excv_q, excv_d;
  logic [XLEN-1:0]       bres_q, bres_d;
  logic [EX_W-1:0]       bexc_q, bexc_d;
  logic                  bexcv_q, bexcv_d;

  // Input decode
  logic            is_load, is_store, is_mem, funct_ok, misal, mem_go;
  logic [1:0]      sz;
  logic [OFFW-1:0] off_in, size_m1;
  logic [NB-1:0]   sz_mask;

  assign is_load  = (opcode_in == OP_LOAD);
  assign is_store = (opcode_in == OP_STORE);
  assign is_mem   = is_load || is_store;
  assign sz       = funct_in[1:0];
  assign off_in   = addr[OFFW-1:0];
  assign size_m1  = OFFW'((32'd1 << sz) - 32'd1);
  assign sz_mask  = NB'((32'd1 << (32'd1 << sz)) - 32'd1);
  assign misal    = |(off_in & size_m1);
  assign mem_go   = is_mem && !exception_in_valid && funct_ok && !misal;

  // Legal size encodings for the decoded access direction and XLEN
  always_comb begin
    funct_ok = 1'b0;
    case (funct_in)
      3'b000, 3'b001, 3'b010: funct_ok = 1'b1;
      3'b011:                 funct_ok = (XLEN == 64);
      3'b100, 3'b101:         funct_ok = is_load;
      3'b110:                 funct_ok = is_load && (XLEN == 64);
      default:                funct_ok = 1'b0;
    endcase
  end

  // Load data alignment and extension, plus the completion record for REQ
  logic [XLEN-1:0] ld_sh, ld_data, done_res;
  logic [EX_W-1:0] done_exc;
  logic            done_excv;

  assign ld_sh = mem_rd_data >> {off_q, 3'b000};

  always_comb begin
    ld_data = ld_sh;
    case (funct_q)
      3'b000:  ld_data = XLEN'($signed(ld_sh[7:0]));
      3'b001:  ld_data = XLEN'($signed(ld_sh[15:0]));
      3'b010:  ld_data = XLEN'($signed(ld_sh[31:0]));
      3'b100:  ld_data = XLEN'(ld_sh[7:0]);
      3'b101:  ld_data = XLEN'(ld_sh[15:0]);
      3'b110:  ld_data = XLEN'(ld_sh[31:0]);
      default: ld_data = ld_sh;
    endcase
    if (mem_ready) begin
      done_res  = we_q ? '0 : ld_data;
      done_exc  = '0;
      done_excv = 1'b0;
    end else begin
      done_res  = XLEN'(addr_q);
      done_exc  = we_q ? EX_ST_FAULT : EX_LD_FAULT;
      done_excv = 1'b1;
    end
  end

  // Next-state and pipeline output update; flush overrides everything else
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    funct_d = funct_q;
    off_d   = off_q;
    addr_d  = addr_q;
    rd_d    = rd_q;
    we_d    = we_q;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    vld_d   = vld_q;
    res_d   = res_q;
    rdo_d   = rdo_q;
    exc_d   = exc_q;
    excv_d  = excv_q;
    bres_d  = bres_q;
    bexc_d  = bexc_q;
    bexcv_d = bexcv_q;
    case (state_q)
      S_IDLE: begin
        if (pipeline_in_valid && !stall_in) begin
          if (mem_go) begin
            state_d = S_REQ;
            cnt_d   = '0;
            funct_d = funct_in;
            off_d   = off_in;
            addr_d  = addr;
            rd_d    = rd_addr_in;
            we_d    = is_store;
            maddr_d = {addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
            wdata_d = result_in << {off_in, 3'b000};
            be_d    = sz_mask << off_in;
            vld_d   = 1'b0;
          end else begin
            vld_d = 1'b1;
            rdo_d = rd_addr_in;
            if (!is_mem || exception_in_valid) begin
              res_d  = result_in;
              exc_d  = exception_in;
              excv_d = exception_in_valid;
            end else if (!funct_ok) begin
              res_d  = XLEN'(addr);
              exc_d  = EX_ILLEGAL;
              excv_d = 1'b1;
            end else begin
              res_d  = XLEN'(addr);
              exc_d  = is_load ? EX_LD_MISAL : EX_ST_MISAL;
              excv_d = 1'b1;
            end
          end
        end else if (!stall_in) begin
          vld_d = 1'b0;
        end
      end
      S_REQ: begin
        if (mem_ready || (cnt_q == CNT_W'(TIMEOUT - 1))) begin
          if (stall_in) begin
            state_d = S_DONE;
            bres_d  = done_res;
            bexc_d  = done_exc;
            bexcv_d = done_excv;
          end else begin
            state_d = S_IDLE;
            vld_d   = 1'b1;
            res_d   = done_res;
            rdo_d   = rd_q;
            exc_d   = done_exc;
            excv_d  = done_excv;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (!stall_in) vld_d = 1'b0;
        end
      end
      S_DONE: begin
        if (!stall_in) begin
          state_d = S_IDLE;
          vld_d   = 1'b1;
          res_d   = bres_q;
          rdo_d   = rd_q;
          exc_d   = bexc_q;
          excv_d  = bexcv_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      vld_d   = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      funct_q <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      vld_q   <= 1'b0;
      res_q   <= '0;
      rdo_q   <= '0;
      exc_q   <= '0;
      excv_q  <= 1'b0;
      bres_q  <= '0;
      bexc_q  <= '0;
      bexcv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      funct_q <= funct_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
      rdo_q   <= rdo_d;
      exc_q   <= exc_d;
      excv_q  <= excv_d;
      bres_q  <= bres_d;
      bexc_q  <= bexc_d;
      bexcv_q <= bexcv_d;
    end
  end

  // Memory outputs are only driven while a request is outstanding
  assign mem_req     = (state_q == S_REQ);
  assign mem_we      = mem_req && we_q;
  assign mem_addr    = mem_req ? maddr_q : '0;
  assign mem_wr_data = mem_req ? wdata_q : '0;
  assign mem_byte_en = mem_req ? be_q    : '0;

  assign pipeline_out_valid  = vld_q;
  assign result_out          = res_q;
  assign rd_addr_out         = rdo_q;
  assign exception_out       = exc_q;
  assign exception_out_valid = excv_q;

  // Gated by reset because the accept term looks at raw inputs
  assign stall_out = !reset && (
      (state_q == S_IDLE && pipeline_in_valid && !stall_in && !flush && mem_go) ||
      (state_q == S_REQ && !mem_ready) ||
      (state_q == S_DONE));

endmodule

// File: tb/tb_lsu_stage.sv
// Directed self-checking bench for lsu_stage (XLEN=32, TIMEOUT=16).
module tb_lsu_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipeline_in_valid;
  logic [4:0]  opcode_in;
  logic [2:0]  funct_in;
  logic [31:0] addr;
  logic [31:0] result_in;
  logic [4:0]  rd_addr_in;
  logic [3:0]  exception_in;
  logic        exception_in_valid;
  logic        pipeline_out_valid;
  logic [31:0] result_out;
  logic [4:0]  rd_addr_out;
  logic [3:0]  exception_out;
  logic        exception_out_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_byte_en;
  logic        mem_ready;
  logic [31:0] mem_rd_data;
  logic        flush;
  logic        stall_in;
  logic        stall_out;

  int checks = 0;
  int passes = 0;

  lsu_stage #(
    .XLEN(32), .ADDR_W(32), .REG_ADDR_W(5), .EX_W(4), .TIMEOUT(16)
  ) dut (
    .clk(clk), .reset(reset),
    .pipeline_in_valid(pipeline_in_valid), .opcode_in(opcode_in),
    .funct_in(funct_in), .addr(addr), .result_in(result_in),
    .rd_addr_in(rd_addr_in), .exception_in(exception_in),
    .exception_in_valid(exception_in_valid),
    .pipeline_out_valid(pipeline_out_valid), .result_out(result_out),
    .rd_addr_out(rd_addr_out), .exception_out(exception_out),
    .exception_out_valid(exception_out_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_byte_en(mem_byte_en),
    .mem_ready(mem_ready), .mem_rd_data(mem_rd_data),
    .flush(flush), .stall_in(stall_in), .stall_out(stall_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] r, input logic [4:0] rd);
    pipeline_in_valid  = 1'b1;
    opcode_in          = op;
    funct_in           = f;
    addr               = a;
    result_in          = r;
    rd_addr_in         = rd;
    exception_in       = 4'd0;
    exception_in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; stall_in = 1'b0;
    mem_ready = 1'b0; mem_rd_data = 32'h0;
    drive(5'b00000, 3'b010, 32'h100, 32'h0, 5'd1);
    step(); step();
    check("rst_valid", pipeline_out_valid, 1'b0);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_result", result_out, 32'h0);
    check("rst_stall_out", stall_out, 1'b0);
    check("rst_excv", exception_out_valid, 1'b0);
    check("rst_byte_en", mem_byte_en, 4'h0);
    pipeline_in_valid = 1'b0;
    reset = 1'b0;

    // pass-through
    drive(5'b01100, 3'b000, 32'h0, 32'h12345678, 5'd7);
    step();
    check("pt_valid", pipeline_out_valid, 1'b1);
    check("pt_result", result_out, 32'h12345678);
    check("pt_rd", rd_addr_out, 5'd7);
    check("pt_excv", exception_out_valid, 1'b0);
    check("pt_mem_req", mem_req, 1'b0);
    drive(5'b01100, 3'b000, 32'h0, 32'h0000CAFE, 5'd2);
    exception_in = 4'd3; exception_in_valid = 1'b1;
    step();
    check("pt_exc", exception_out, 4'd3);
    check("pt_exc_valid", exception_out_valid, 1'b1);
    check("pt_exc_result", result_out, 32'h0000CAFE);
    pipeline_in_valid = 1'b0; exception_in_valid = 1'b0;
    step();
    check("bubble_valid", pipeline_out_valid, 1'b0);

    // LB with sign extension, ready in the first REQ cycle
    drive(5'b00000, 3'b000, 32'h103, 32'h0, 5'd5);
    #1 check("lb_stall_accept", stall_out, 1'b1);
    step();
    pipeline_in_valid = 1'b0;
    check("lb_mem_req", mem_req, 1'b1);
    check("lb_mem_we", mem_we, 1'b0);
    check("lb_mem_addr", mem_addr, 32'h100);
    check("lb_byte_en", mem_byte_en, 4'b1000);
    check("lb_valid_req", pipeline_out_valid, 1'b0);
    mem_ready = 1'b1; mem_rd_data = 32'h80FF1234;
    #1 check("lb_stall_ready", stall_out, 1'b0);
    step();
    mem_ready = 1'b0;
    check("lb_valid", pipeline_out_valid, 1'b1);
    check("lb_result", result_out, 32'hFFFFFF80);
    check("lb_rd", rd_addr_out, 5'd5);
    check("lb_mem_req_done", mem_req, 1'b0);

    // SH with one wait cycle
    drive(5'b01000, 3'b001, 32'h102, 32'h0000ABCD, 5'd1);
    step();
    pipeline_in_valid = 1'b0;
    check("sh_mem_req", mem_req, 1'b1);
    check("sh_mem_we", mem_we, 1'b1);
    check("sh_mem_addr", mem_addr, 32'h100);
    check("sh_byte_en", mem_byte_en, 4'b1100);
    check("sh_wr_data", mem_wr_data, 32'hABCD0000);
    #1 check("sh_stall_wait", stall_out, 1'b1);
    step();
    check("sh_wr_hold", mem_wr_data, 32'hABCD0000);
    check("sh_req_hold", mem_req, 1'b1);
    mem_ready = 1'b1;
    step();
    mem_ready = 1'b0;
    check("sh_valid", pipeline_out_valid, 1'b1);
    check("sh_excv", exception_out_valid, 1'b0);
    check("sh_req_drop", mem_req, 1'b0);

    // LH and LBU load extraction
    drive(5'b00000, 3'b001, 32'h102, 32'h0, 5'd2);
    step();
    pipeline_in_valid = 1'b0; mem_ready = 1'b1; mem_rd_data = 32'h80010000;
    step();
    mem_ready = 1'b0;
    check("lh_result", result_out, 32'hFFFF8001);
    drive(5'b00000, 3'b100, 32'h101, 32'h0, 5'd2);
    step();
    pipeline_in_valid = 1'b0; mem_ready = 1'b1; mem_rd_data = 32'h0000F000;
    step();
    mem_ready = 1'b0;
    check("lbu_result", result_out, 32'h000000F0);

    // misaligned and illegal accesses
    drive(5'b00000, 3'b010, 32'h201, 32'h0, 5'd8);
    #1 check("lw_mis_stall", stall_out, 1'b0);
    step();
    check("lw_mis_valid", pipeline_out_valid, 1'b1);
    check("lw_mis_exc", exception_out, 4'd4);
    check("lw_mis_excv", exception_out_valid, 1'b1);
    check("lw_mis_result", result_out, 32'h201);
    check("lw_mis_rd", rd_addr_out, 5'd8);
    check("lw_mis_no_req", mem_req, 1'b0);
    drive(5'b01000, 3'b010, 32'h202, 32'h55, 5'd0);
    step();
    check("sw_mis_exc", exception_out, 4'd6);
    check("sw_mis_result", result_out, 32'h202);
    drive(5'b00000, 3'b111, 32'h200, 32'h0, 5'd0);
    step();
    check("ld_ill_exc", exception_out, 4'd2);
    check("ld_ill_no_req", mem_req, 1'b0);
    drive(5'b00000, 3'b011, 32'h208, 32'h0, 5'd0);
    step();
    check("ld64_ill_exc", exception_out, 4'd2);
    drive(5'b01000, 3'b100, 32'h200, 32'h0, 5'd0);
    step();
    check("st_ill_exc", exception_out, 4'd2);
    pipeline_in_valid = 1'b0;
    step();
    check("idle_bubble", pipeline_out_valid, 1'b0);

    // LHU timeout
    drive(5'b00000, 3'b101, 32'h300, 32'h0, 5'd9);
    step();
    pipeline_in_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("to_req_%0d", i), mem_req, 1'b1);
      step();
    end
    check("to_req_drop", mem_req, 1'b0);
    check("to_valid", pipeline_out_valid, 1'b1);
    check("to_exc", exception_out, 4'd5);
    check("to_excv", exception_out_valid, 1'b1);
    check("to_result", result_out, 32'h300);
    check("to_rd", rd_addr_out, 5'd9);

    // ready while downstream stalled for 3 cycles
    drive(5'b00000, 3'b010, 32'h400, 32'h0, 5'd3);
    step();
    pipeline_in_valid = 1'b0;
    stall_in = 1'b1; mem_ready = 1'b1; mem_rd_data = 32'hDEADBEEF;
    step();
    mem_ready = 1'b0; mem_rd_data = 32'h0;
    check("st_done_stall_out", stall_out, 1'b1);
    check("st_done_no_req", mem_req, 1'b0);
    step(); step();
    check("st_hold_stall_out", stall_out, 1'b1);
    check("st_hold_valid", pipeline_out_valid, 1'b0);
    check("st_hold_result", result_out, 32'h300);
    stall_in = 1'b0;
    #1 check("st_release_stall_out", stall_out, 1'b1);
    step();
    check("st_valid", pipeline_out_valid, 1'b1);
    check("st_result", result_out, 32'hDEADBEEF);
    check("st_rd", rd_addr_out, 5'd3);
    check("st_excv", exception_out_valid, 1'b0);
    stall_in = 1'b1;
    step();
    check("hold_valid", pipeline_out_valid, 1'b1);
    check("hold_result", result_out, 32'hDEADBEEF);
    stall_in = 1'b0;
    step();
    check("hold_release_bubble", pipeline_out_valid, 1'b0);

    // reset mid-REQ, then flush mid-REQ
    drive(5'b00000, 3'b010, 32'h500, 32'h0, 5'd10);
    step();
    pipeline_in_valid = 1'b0;
    check("rr_req", mem_req, 1'b1);
    reset = 1'b1;
    #1;
    check("rr_req_drop", mem_req, 1'b0);
    check("rr_stall_out", stall_out, 1'b0);
    check("rr_mem_addr", mem_addr, 32'h0);
    reset = 1'b0;
    #1;
    drive(5'b00000, 3'b010, 32'h600, 32'h0, 5'd4);
    step();
    pipeline_in_valid = 1'b0;
    check("rr_accept", mem_req, 1'b1);
    check("rr_accept_addr", mem_addr, 32'h600);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_req_drop", mem_req, 1'b0);
    check("fl_valid", pipeline_out_valid, 1'b0);
    drive(5'b00000, 3'b010, 32'h604, 32'h0, 5'd6);
    step();
    pipeline_in_valid = 1'b0;
    check("fl_next_req", mem_req, 1'b1);
    check("fl_next_addr", mem_addr, 32'h604);
    mem_ready = 1'b1; mem_rd_data = 32'h11223344;
    step();
    mem_ready = 1'b0;
    check("fl_next_valid", pipeline_out_valid, 1'b1);
    check("fl_next_result", result_out, 32'h11223344);
    check("fl_next_rd", rd_addr_out, 5'd6);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/lsu_stage.md
LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 Parameter XLEN, 32, data and register width; legal values are 32 and 64.
REQ-002 Parameter ADDR_W, 32, address width.
REQ-003 Parameter REG_ADDR_W, 5, destination register index width.
REQ-004 Parameter EX_W, 4, exception code width.
REQ-005 Parameter TIMEOUT, 16, maximum REQ cycles before an access fault; minimum value 2.
REQ-006 Ports, in order: clk in 1, rising-edge clock; reset in 1, asynchronous, active-high.
REQ-007 Pipeline-in ports: pipeline_in_valid in 1; opcode_in in 5; funct_in in 3; addr in ADDR_W; result_in in XLEN (store data or pass-through result); rd_addr_in in REG_ADDR_W; exception_in in EX_W; exception_in_valid in 1.
REQ-008 Pipeline-out ports: pipeline_out_valid out 1; result_out out XLEN; rd_addr_out out REG_ADDR_W; exception_out out EX_W; exception_out_valid out 1.
REQ-009 Data-memory ports: mem_req out 1; mem_we out 1; mem_addr out ADDR_W; mem_wr_data out XLEN; mem_byte_en out XLEN/8; mem_ready in 1; mem_rd_data in XLEN.
REQ-010 Control ports: flush in 1, synchronous; stall_in in 1, downstream hold; stall_out out 1, upstream hold.

Function
REQ-011 The block SHALL use opcode 5'b00000 for LOAD and 5'b01000 for STORE; every other opcode is pass-through.
REQ-012 The block SHALL implement a state machine with states IDLE, REQ and DONE.
REQ-013 In IDLE with pipeline_in_valid=1 and stall_in=0, the block SHALL accept the input at the next clock edge.
REQ-014 Pass-through, exception_in_valid=1, misaligned and illegal inputs SHALL appear on the outputs 1 cycle after acceptance and SHALL NOT assert mem_req.
REQ-015 For pass-through inputs, result_out SHALL equal result_in and exception_in SHALL propagate unchanged.
REQ-016 An aligned, legal LOAD or STORE SHALL register its fields and move IDLE->REQ.
REQ-017 stall_out SHALL be driven combinationally high in the accept cycle of a memory operation, in REQ (except the mem_ready cycle) and in DONE.
REQ-018 In REQ, the block SHALL ignore its inputs, hold mem_req=1, hold all memory outputs stable, and count REQ cycles.
REQ-019 On mem_ready=1 in REQ, the block SHALL capture load data and go to IDLE with the outputs updated, or go to DONE if stall_in=1.
REQ-020 DONE SHALL hold the buffered result until stall_in=0, then present it and go to IDLE.
REQ-021 If mem_ready stays 0 for TIMEOUT REQ cycles, the block SHALL drop mem_req and complete with an access fault (load 5, store 7), with result_out equal to addr.
REQ-022 mem_addr SHALL equal addr with its log2(XLEN/8) low bits cleared.
REQ-023 The byte offset SHALL be those low address bits.
REQ-024 mem_byte_en SHALL equal the size mask shifted left by the byte offset; mem_wr_data SHALL equal result_in shifted left by 8 times the offset.
REQ-025 funct sizes SHALL be: 000 byte, 001 half, 010 word, 011 double (XLEN=64 only); loads with 100, 101, 110 are the zero-extending byte, half and word (XLEN=64 only) variants.
REQ-026 Load data SHALL be mem_rd_data shifted right by 8 times the offset, then sign- or zero-extended to XLEN.
REQ-027 An access whose offset is not a multiple of its size SHALL raise a misaligned exception (load 4, store 6) with result_out equal to addr.
REQ-028 Unsupported funct values SHALL raise exception code 2.
REQ-029 exception_out_valid SHALL be 1 only for a propagated or internally raised exception.
REQ-030 When stall_in=1, all pipeline outputs SHALL hold their values.
REQ-031 When no instruction is accepted and stall_in=0, pipeline_out_valid SHALL clear to 0 (bubble).
REQ-032 rd_addr_out SHALL carry the rd_addr_in of the completing instruction.
REQ-033 flush=1 SHALL, at the next edge, force IDLE, clear mem_req, pipeline_out_valid and the counter, and abandon any outstanding access; the memory commits nothing without mem_ready.
REQ-034 flush SHALL take priority over stall_in, mem_ready and acceptance.

Reset
REQ-035 While reset=1, the state SHALL be IDLE and the counter 0, independent of clk.
REQ-036 While reset=1, every output (mem_req, mem_we, mem_addr, mem_wr_data, mem_byte_en, pipeline_out_valid, result_out, rd_addr_out, exception_out, exception_out_valid, stall_out) SHALL be 0.
REQ-037 Reset asserted mid-REQ SHALL drop mem_req immediately, and the first edge after release SHALL be able to accept a new input.

Verification
REQ-038 LB, addr 0x103, mem_rd_data 0x80FF1234, mem_ready in the first REQ cycle -> result_out 0xFFFFFF80, pipeline_out_valid 2 cycles after acceptance.
REQ-039 SH, addr 0x102, result_in 0x0000ABCD -> mem_addr 0x100, mem_byte_en 4'b1100, mem_wr_data 0xABCD0000, mem_we=1.
REQ-040 LW, addr 0x201 -> no mem_req; exception_out 4, result_out 0x201, 1-cycle latency.
REQ-041 LHU, mem_ready held 0, TIMEOUT=16 -> mem_req drops after 16 REQ cycles; exception_out 5.
REQ-042 mem_ready arrives while stall_in is high for 3 cycles -> DONE, stall_out high; result appears the cycle after stall_in falls, value intact.
REQ-043 reset pulsed mid-REQ, then flush during a later REQ -> mem_req 0 immediately on reset, and 0 at the edge after flush; the next LW is accepted normally.
